uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter among NREQ byte-stream requesters (e.g. frame renderer, status/debug printer).

---
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter_if : requester byte lanes and UART transmitter handshake   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_txe;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  req_valid, req_data, req_last, tx_txe,
    output req_ready, tx_start, tx_data, grant, busy, timeout_err
  );

  modport slave (
    output req_valid, req_data, req_last, tx_txe,
    input  req_ready, tx_start, tx_data, grant, busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin, packet-locked sharing of one UART TX        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int NREQ         = 3,
  parameter int IDLE_TIMEOUT = 64
) (
  input  wire logic         clk,
  input  wire logic         nrst,
  uart_tx_arbiter_if.master bus_io
);

  localparam int OW  = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  localparam logic [WDW-1:0] c_WD_LAST    = WDW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic [OW-1:0]  c_LAST_RESET = OW'(NREQ - 1);

  localparam logic [1:0] c_ST_ARB  = 2'd0;
  localparam logic [1:0] c_ST_LOCK = 2'd1;
  localparam logic [1:0] c_ST_GAP  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_owner_q, last_owner_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            tout_q, tout_d;

  logic            w_pick_vld;
  logic [OW-1:0]   w_pick_idx;
  logic            w_own_valid;
  logic            w_own_last;
  logic [7:0]      w_own_data;
  logic [NREQ-1:0] w_own_onehot;
  logic            w_acc;
  logic [NREQ-1:0] w_req_ready;
  logic            w_tx_start;
  logic [7:0]      w_tx_data;

  // Rotating scan starting just after the previous owner.
  always_comb begin
    int cand;
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    cand       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_owner_q) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!w_pick_vld && bus_io.req_valid[cand[OW-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = cand[OW-1:0];
      end
    end
  end

  assign w_own_valid  = bus_io.req_valid[owner_q];
  assign w_own_last   = bus_io.req_last[owner_q];
  assign w_own_data   = bus_io.req_data[{owner_q, 3'b000} +: 8];
  assign w_own_onehot = NREQ'(1) << owner_q;
  assign w_acc        = (state_q == c_ST_LOCK) && w_own_valid && bus_io.tx_txe;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= c_ST_ARB;
      owner_q      <= '0;
      last_owner_q <= c_LAST_RESET;
      wd_q         <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      tout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wd_q         <= wd_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      tout_q       <= tout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wd_d         = wd_q;
    tout_d       = 1'b0;
    case (state_q)
      c_ST_ARB: begin
        wd_d = '0;
        if (w_pick_vld) begin
          state_d = c_ST_LOCK;
          owner_d = w_pick_idx;
        end
      end
      c_ST_LOCK: begin
        if (w_acc) begin
          wd_d = '0;
          if (w_own_last) begin
            state_d      = c_ST_ARB;
            last_owner_d = owner_q;
          end else begin
            state_d = c_ST_GAP;
          end
        end else if (w_own_valid) begin
          // Owner is ready but the transmitter is not: not an idle owner.
          wd_d = '0;
        end else if ((IDLE_TIMEOUT != 0) && (wd_q == c_WD_LAST)) begin
          state_d      = c_ST_ARB;
          last_owner_d = owner_q;
          tout_d       = 1'b1;
          wd_d         = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      c_ST_GAP: begin
        state_d = c_ST_LOCK;
      end
      default: begin
        state_d = c_ST_ARB;
      end
    endcase
    busy_d  = (state_d != c_ST_ARB);
    grant_d = busy_d ? (NREQ'(1) << owner_d) : '0;
  end

  always_comb begin
    w_req_ready = '0;
    w_tx_start  = 1'b0;
    w_tx_data   = 8'h00;
    if ((state_q == c_ST_LOCK) && bus_io.tx_txe) begin
      w_req_ready = w_own_onehot;
    end
    if (w_acc) begin
      w_tx_start = 1'b1;
      w_tx_data  = w_own_data;
    end
  end

  assign bus_io.req_ready   = w_req_ready;
  assign bus_io.tx_start    = w_tx_start;
  assign bus_io.tx_data     = w_tx_data;
  assign bus_io.grant       = grant_q;
  assign bus_io.busy        = busy_q;
  assign bus_io.timeout_err = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_arbiter : directed checks of the shared UART TX arbiter         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  logic        clk  = 1'b0;
  logic        nrst = 1'b0;
  logic [2:0]  v    = '0;
  logic [2:0]  l    = '0;
  logic [23:0] d    = '0;
  logic        txe  = 1'b1;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(3)) bus ();

  assign bus.req_valid = v;
  assign bus.req_data  = d;
  assign bus.req_last  = l;
  assign bus.tx_txe    = txe;

  uart_tx_arbiter #(.NREQ(3), .IDLE_TIMEOUT(16)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .bus_io (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic lane(input int i, input logic vv, input logic [7:0] dd, input logic ll);
    v[i]        = vv;
    d[i*8 +: 8] = dd;
    l[i]        = ll;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [2:0] exp_g [6];
  logic [7:0] exp_d [6];

  initial begin
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_d = '{8'hA0, 8'hB1, 8'hC2, 8'hA0, 8'hB1, 8'hC2};

    // Reset values
    nrst = 1'b0;
    txe  = 1'b1;
    tick; tick; settle;
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_start", bus.tx_start, 0);
    chk("rst_data", bus.tx_data, 0);
    chk("rst_tout", bus.timeout_err, 0);

    // 1: lane 0 three-byte packet
    nrst = 1'b1;
    lane(0, 1'b1, 8'h41, 1'b0);
    settle;
    chk("t1_arb_grant", bus.grant, 0);
    chk("t1_arb_ready", bus.req_ready, 0);
    chk("t1_arb_start", bus.tx_start, 0);
    tick; settle;
    chk("t1_grant", bus.grant, 3'b001);
    chk("t1_busy", bus.busy, 1);
    chk("t1_start0", bus.tx_start, 1);
    chk("t1_byte0", bus.tx_data, 8'h41);
    tick; lane(0, 1'b1, 8'h42, 1'b0); settle;
    chk("t1_gap_start", bus.tx_start, 0);
    chk("t1_gap_data", bus.tx_data, 0);
    chk("t1_gap_ready", bus.req_ready, 0);
    chk("t1_gap_busy", bus.busy, 1);
    tick; settle;
    chk("t1_start1", bus.tx_start, 1);
    chk("t1_byte1", bus.tx_data, 8'h42);
    tick; lane(0, 1'b1, 8'h43, 1'b1); settle;
    chk("t1_gap2_start", bus.tx_start, 0);
    tick; settle;
    chk("t1_start2", bus.tx_start, 1);
    chk("t1_byte2", bus.tx_data, 8'h43);
    tick; lane(0, 1'b0, 8'h00, 1'b0); settle;
    chk("t1_end_busy", bus.busy, 0);
    chk("t1_end_grant", bus.grant, 0);
    chk("t1_end_start", bus.tx_start, 0);

    // 2: lanes 0 and 1 contend after reset, packets must not interleave
    nrst = 1'b0;
    lane(0, 1'b1, 8'h10, 1'b0);
    lane(1, 1'b1, 8'h20, 1'b0);
    tick; nrst = 1'b1; settle;
    chk("t2_arb_start", bus.tx_start, 0);
    tick; settle;
    chk("t2_grant0", bus.grant, 3'b001);
    chk("t2_b0", bus.tx_data, 8'h10);
    chk("t2_ready0", bus.req_ready, 3'b001);
    tick; lane(0, 1'b1, 8'h11, 1'b1); settle;
    chk("t2_gap0", bus.tx_start, 0);
    tick; settle;
    chk("t2_start1", bus.tx_start, 1);
    chk("t2_b1", bus.tx_data, 8'h11);
    chk("t2_grant1", bus.grant, 3'b001);
    tick; lane(0, 1'b0, 8'h00, 1'b0); settle;
    chk("t2_arb_start2", bus.tx_start, 0);
    chk("t2_arb_grant", bus.grant, 0);
    tick; settle;
    chk("t2_grant2", bus.grant, 3'b010);
    chk("t2_b2", bus.tx_data, 8'h20);
    tick; lane(1, 1'b1, 8'h21, 1'b1); settle;
    chk("t2_gap1", bus.tx_start, 0);
    tick; settle;
    chk("t2_b3", bus.tx_data, 8'h21);
    tick; lane(1, 1'b0, 8'h00, 1'b0); settle;
    chk("t2_end_busy", bus.busy, 0);

    // 3: three lanes offering 1-byte packets rotate 0,1,2,0,1,2
    nrst = 1'b0;
    tick; nrst = 1'b1;
    v = 3'b111;
    l = 3'b111;
    d = {8'hC2, 8'hB1, 8'hA0};
    settle;
    for (int i = 0; i < 6; i++) begin
      tick; settle;
      chk("t3_grant", bus.grant, exp_g[i]);
      chk("t3_data", bus.tx_data, exp_d[i]);
      tick; settle;
      chk("t3_arb_busy", bus.busy, 0);
    end
    v = 3'b000;
    l = 3'b000;

    // 4: lane 2 holds the lock while the transmitter is full
    lane(2, 1'b1, 8'hE7, 1'b1);
    txe = 1'b0;
    settle;
    tick; settle;
    for (int i = 0; i < 20; i++) begin
      chk("t4_hold", {bus.tx_start, bus.req_ready, bus.timeout_err, bus.grant}, 8'b0000_0100);
      tick; settle;
    end
    txe = 1'b1;
    settle;
    chk("t4_start", bus.tx_start, 1);
    chk("t4_data", bus.tx_data, 8'hE7);
    chk("t4_ready", bus.req_ready, 3'b100);
    tick; lane(2, 1'b0, 8'h00, 1'b0); settle;
    chk("t4_end_busy", bus.busy, 0);

    // 5: idle owner watchdog with lane 2 waiting
    lane(1, 1'b1, 8'h55, 1'b0);
    lane(2, 1'b1, 8'h66, 1'b1);
    settle;
    tick; settle;
    chk("t5_grant1", bus.grant, 3'b010);
    chk("t5_start", bus.tx_start, 1);
    chk("t5_data", bus.tx_data, 8'h55);
    tick; lane(1, 1'b0, 8'h00, 1'b0); settle;
    for (int i = 0; i < 16; i++) begin
      tick; settle;
      chk("t5_idle", {bus.timeout_err, bus.grant}, 4'b0010);
    end
    tick; settle;
    chk("t5_tout", bus.timeout_err, 1);
    chk("t5_tout_busy", bus.busy, 0);
    chk("t5_tout_grant", bus.grant, 0);
    tick; settle;
    chk("t5_tout_once", bus.timeout_err, 0);
    chk("t5_grant2", bus.grant, 3'b100);
    chk("t5_data2", bus.tx_data, 8'h66);
    tick; lane(2, 1'b0, 8'h00, 1'b0); settle;

    // 6: reset in the middle of a lane 1 packet
    lane(1, 1'b1, 8'h77, 1'b0);
    settle;
    tick; settle;
    chk("t6_grant1", bus.grant, 3'b010);
    chk("t6_data", bus.tx_data, 8'h77);
    tick; lane(1, 1'b1, 8'h78, 1'b0); nrst = 1'b0; settle;
    tick; settle;
    chk("t6_rst_grant", bus.grant, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_ready", bus.req_ready, 0);
    chk("t6_rst_start", bus.tx_start, 0);
    chk("t6_rst_data", bus.tx_data, 0);
    chk("t6_rst_tout", bus.timeout_err, 0);
    nrst = 1'b1;
    lane(0, 1'b1, 8'h01, 1'b1);
    settle;
    tick; settle;
    chk("t6_grant0", bus.grant, 3'b001);
    chk("t6_start0", bus.tx_start, 1);
    chk("t6_data0", bus.tx_data, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
